vend_controller: RTL
====================

// Module: vend_controller
// PURPOSE
//  Transaction sequencer for the multi-item vending machine.
//  - Latches an item selection, accumulates nickel/dime credit against that item's price.
//  - Issues a one-cycle dispense, then returns change or a refund one nickel per cycle.
//  - Tracks per-item stock and enforces an inactivity timeout.
//  Sits between the coin acceptor / keypad front end and the dispense and coin-return actuators.
// PARAMETERS
//  NUM_ITEMS    4    number of selectable items (item index width = 2)
//  STOCK_INIT   8    units per item after reset or restock (stock counters 4 bits)
//  TIMEOUT_CYC  1000 idle cycles in COLLECT before automatic refund
//  CREDIT_W     4    credit width in nickel units
// PORTS
//  clock        in   1  rising-edge clock
//  reset_n      in   1  asynchronous, active-low reset
//  item_sel     in   2  requested item index
//  sel_valid    in   1  item_sel is valid this cycle
//  nickel_in    in   1  one nickel accepted this cycle
//  dime_in      in   1  one dime accepted this cycle
//  cancel       in   1  customer cancel request
//  restock      in   1  reload all stock counters to STOCK_INIT
//  dispense     out  1  one-cycle pulse, release item item_out
//  item_out     out  2  item being dispensed; valid only while dispense=1
//  nickel_out   out  1  one-cycle pulse, return one nickel
//  coin_reject  out  1  one-cycle pulse, coin sampled this edge was not credited
//  busy         out  1  state != IDLE
//  credit       out  4  current credit in nickels
//  sold_out     out  4  bit i = stock of item i is zero
// BEHAVIOUR
//  - All outputs are registered.
//    Reset values: dispense/nickel_out/coin_reject/busy = 0, credit = 0, item_out = 0, sold_out = 0.
//    Stock = STOCK_INIT, state = IDLE.
//  - Coin values: nickel = 1 unit, dime = 2 units.
//  - Prices are 3/4/5/6 nickels for items 0..3 (15/20/25/30 cents).
//  - IDLE:
//    - sel_valid with !sold_out[item_sel]: latch the selection, go to COLLECT, clear the timer.
//    - Selecting a sold-out item is ignored; the FSM stays in IDLE.
//    - Any coin in IDLE raises coin_reject the next cycle and is not credited.
//    - restock is honoured only in IDLE and takes priority over sel_valid.
//  - COLLECT:
//    - Credit is updated at the sampling edge.
//    - nickel_in and dime_in together: the nickel is credited, the dime is rejected (coin_reject).
//    - sel_valid and restock are ignored.
//    - If credit after the update is >= price: go to DISPENSE, so dispense is high in the next cycle.
//    - cancel with a coin in the same cycle: the coin is credited, then go to REFUND.
//      If that coin also reaches the price, the purchase wins.
//    - Any coin clears the timer.
//    - The timer reaching TIMEOUT_CYC-1 with no coin: go to REFUND; with credit=0, go straight to IDLE.
//  - DISPENSE (exactly 1 cycle):
//    - dispense=1, item_out=latched item, stock of that item decremented.
//    - credit <= credit - price.
//    - Next state is CHANGE if the remainder is > 0, else IDLE.
//    - Maximum remainder is 1 nickel (dime at price-1).
//  - CHANGE / REFUND: nickel_out=1 for exactly one cycle per credit unit, credit decrements each cycle.
//    Return to IDLE on the cycle credit reaches 0. No back-to-back gaps.
//  - Coins arriving in DISPENSE, CHANGE or REFUND are rejected (coin_reject, never credited).
//  - Stock never underflows: an item with zero stock cannot be selected.
//    sold_out is updated on the decrement edge.
//  - Credit saturation is impossible by construction (max 7 units fits CREDIT_W).
//    Assertion: credit <= price+1 at all times.
//  - Asynchronous reset mid-transaction aborts the transaction with no refund.
//    All state returns to reset values immediately.
// STRUCTURE
//  - vend_pkg:
//    - state encoding (IDLE, COLLECT, DISPENSE, CHANGE, REFUND; one-hot, 5 bits)
//    - PRICE[0:3] table
//    - NICKEL_VAL and DIME_VAL constants
//  - Sub-module vend_stock_bank: NUM_ITEMS stock counters with load (restock), decrement-by-index and sold_out flags.
//  - The FSM, credit register and timeout counter stay in vend_controller.
// TESTING
//  1. Select item 2 (price 5); apply dime, dime, nickel.
//     -> credit 2,4,5; dispense=1 with item_out=2 one cycle after the nickel; no nickel_out; back in IDLE.
//  2. Select item 0 (price 3); apply dime, dime.
//     -> dispense pulse, then exactly one nickel_out pulse, credit 0, IDLE.
//  3. Select item 3; apply nickel, dime, then cancel.
//     -> three consecutive nickel_out pulses, no dispense, IDLE.
//  4. Select item 1; apply nickel and dime in the same cycle.
//     -> credit 1, coin_reject pulse; then idle TIMEOUT_CYC cycles -> one nickel_out pulse.
//  5. Buy item 1 STOCK_INIT times.
//     -> sold_out[1]=1; the next selection of item 1 keeps busy=0; restock clears sold_out[1].
//  6. Pull reset_n low during CHANGE.
//     -> nickel_out drops immediately; credit=0, busy=0; no further pulses after release.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared constants, price table and state encoding for the vending controller
package vend_pkg;
  localparam int NUM_ITEMS   = 4;
  localparam int ITEM_W      = 2;
  localparam int STOCK_INIT  = 8;
  localparam int STOCK_W     = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int TIMER_W     = $clog2(TIMEOUT_CYC);
  localparam int CREDIT_W    = 4;

  localparam logic [CREDIT_W-1:0] NICKEL_VAL = 4'd1;
  localparam logic [CREDIT_W-1:0] DIME_VAL   = 4'd2;

  // Prices in nickels for items 0..3
  localparam logic [CREDIT_W-1:0] PRICE [NUM_ITEMS] = '{4'd3, 4'd4, 4'd5, 4'd6};

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_COLLECT  = 5'b00010,
    S_DISPENSE = 5'b00100,
    S_CHANGE   = 5'b01000,
    S_REFUND   = 5'b10000
  } state_t;
endpackage

// File: rtl/vend_stock_bank.sv
// rtl/vend_stock_bank.sv - per-item stock counters with reload, indexed decrement and sold-out flags
module vend_stock_bank
  import vend_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 dec_en,
  input  logic [ITEM_W-1:0]    dec_idx,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock [NUM_ITEMS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      sold_out <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      sold_out <= '0;
    end else if (dec_en && stock[dec_idx] != '0) begin
      // Flag is registered on the same edge the last unit leaves
      stock[dec_idx]    <= stock[dec_idx] - STOCK_W'(1);
      sold_out[dec_idx] <= (stock[dec_idx] == STOCK_W'(1));
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending transaction sequencer: select, collect credit, dispense, pay out change/refund
module vend_controller
  import vend_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ITEM_W-1:0]    item_sel,
  input  logic                 sel_valid,
  input  logic                 nickel_in,
  input  logic                 dime_in,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 dispense,
  output logic [ITEM_W-1:0]    item_out,
  output logic                 nickel_out,
  output logic                 coin_reject,
  output logic                 busy,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out
);

  state_t              state;
  logic [ITEM_W-1:0]   item;
  logic [TIMER_W-1:0]  timer;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_upd;
  logic [CREDIT_W-1:0] remainder;
  logic                coin_any;
  logic                dec_en;
  logic                load_en;

  always_comb begin
    price      = PRICE[item];
    // A simultaneous dime is dropped in favour of the nickel
    coin_val   = nickel_in ? NICKEL_VAL : (dime_in ? DIME_VAL : '0);
    credit_upd = credit + coin_val;
    remainder  = credit - price;
    coin_any   = nickel_in | dime_in;
    dec_en     = (state == S_DISPENSE);
    load_en    = restock && (state == S_IDLE);
  end

  vend_stock_bank u_stock (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load_en),
    .dec_en   (dec_en),
    .dec_idx  (item),
    .sold_out (sold_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      item        <= '0;
      timer       <= '0;
      credit      <= '0;
      dispense    <= 1'b0;
      item_out    <= '0;
      nickel_out  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      item_out    <= '0;
      nickel_out  <= 1'b0;
      coin_reject <= coin_any;
      case (state)
        S_IDLE: begin
          if (!restock && sel_valid && !sold_out[item_sel]) begin
            item  <= item_sel;
            timer <= '0;
            state <= S_COLLECT;
            busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          coin_reject <= nickel_in & dime_in;
          credit      <= credit_upd;
          if (credit_upd >= price) begin
            state    <= S_DISPENSE;
            dispense <= 1'b1;
            item_out <= item;
          end else if (cancel || (!coin_any && timer == TIMER_W'(TIMEOUT_CYC - 1))) begin
            if (credit_upd == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              // First nickel goes out in the very next cycle; credit shows what remains after it
              state      <= S_REFUND;
              nickel_out <= 1'b1;
              credit     <= credit_upd - CREDIT_W'(1);
            end
          end else if (coin_any) begin
            timer <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        S_DISPENSE: begin
          if (remainder != '0) begin
            state      <= S_CHANGE;
            nickel_out <= 1'b1;
            credit     <= remainder - CREDIT_W'(1);
          end else begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            credit <= '0;
          end
        end
        S_CHANGE, S_REFUND: begin
          if (credit != '0) begin
            nickel_out <= 1'b1;
            credit     <= credit - CREDIT_W'(1);
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          credit <= '0;
        end
      endcase
    end
  end

  credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
    ({1'b0, credit} <= ({1'b0, price} + 5'd1)));

endmodule
